cbus_arbiter_rr: RTL
====================

Name: cbus_arbiter_rr

Overview:
- N-port cache-bus (CBus) arbiter, successor to the fixed two-port arbiter that sits between the IBus/DBus converters and the RAM helper.
- Generalised to NUM_PORTS requesters (instruction, data, future DMA/PTW).
- Two selectable policies: fixed priority and round-robin.
- Holds a grant for a whole burst, until the response beat with last set; never interleaves beats from different requesters.

Parameters:
- NUM_PORTS, 2: number of requesters, >=2; port 0 is highest priority in fixed mode.
- RR_EN, 1: 1 = round-robin policy, 0 = fixed priority (lowest index wins).
- IDX_W, $clog2(NUM_PORTS): grant index width; derived, not overridden.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- ireqs  in  NUM_PORTS x cbus_req_t  per-port requests.
- iresps  out  NUM_PORTS x cbus_resp_t  per-port responses.
- oreq  out  cbus_req_t  request to memory.
- oresp  in  cbus_resp_t  response from memory.
- grant_cnt  out  NUM_PORTS x 32  per-port completed-transaction counters; present only with CBUS_ARB_PERF_EN.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port name reset.
- State: IDLE, BUSY. Registers:
  - idx (IDX_W): current grant.
  - rr_ptr (IDX_W): next highest-priority port for round-robin.
- Reset: state=IDLE, idx=0, rr_ptr=0.
  - oreq='0, all iresps='0 in the cycle after reset is sampled high.
  - Reset mid-burst abandons the burst; no response reaches any port afterwards.

IDLE:
- oreq='0, all iresps='0.
- If any ireqs[i].valid: pick a winner, load idx, go to BUSY next edge.
- Arbitration latency is exactly 1 cycle from valid to oreq.valid.
- Fixed policy: lowest valid index wins.
- Round-robin policy: first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS.

BUSY:
- oreq = ireqs[idx]; iresps[idx] = oresp; all other iresps = '0.
- A non-granted requester sees ready=0 and simply waits.
- Completion is oresp.ready && oresp.last. On completion:
  - state returns to IDLE.
  - In RR mode, rr_ptr <= idx+1, wrapping to 0 when idx == NUM_PORTS-1.
- Requests arriving during BUSY are not sampled; they compete at the next IDLE cycle.
- Minimum one IDLE bubble between transactions.
- If the granted port drops valid mid-burst, the arbiter stays BUSY and forwards as-is until last.
  - This is a protocol violation; an assertion flags it in simulation only.
- Multi-beat bursts: ready without last keeps BUSY and idx unchanged.
- Single-beat: ready and last in the same cycle.
- Simultaneous completion and a new valid on another port: the new request is arbitrated in the following IDLE cycle, using the updated rr_ptr.
- No other side effects: no buffering, oreq/iresps are combinational from registered idx/state.

Optional Feature:
- CBUS_ARB_PERF_EN defined:
  - grant_cnt[i] increments by 1 at each completion when idx==i; wraps at 2^32.
  - Cleared by reset.
  - Port list includes grant_cnt.
- Undefined: grant_cnt port and counters absent; all other behaviour identical.

Decomposition:
- cbus_req_t, cbus_resp_t stay in the common package.
- Add to the common package:
  - arb_state_t enum (ARB_IDLE, ARB_BUSY).
  - Constant CBUS_ARB_MAX_PORTS=8.
- One sub-module: cbus_arb_pick. Purely combinational.
  - Inputs: valid vector, rr_ptr, mode.
  - Outputs: winner index and any_valid.
  - Reused by future bus muxes.

Test Plan:
- NUM_PORTS=2, fixed policy, both valid at cycle 0 with len=0 -> port 0 granted at cycle 1; port 1 granted the cycle after port 0 sees ready&&last.
- NUM_PORTS=4, RR, all four continuously valid, single-beat with ready=1 each BUSY cycle -> grant order 0,1,2,3,0; each BUSY separated by one IDLE.
- Port 2 burst len=3 (4 beats), ready each cycle, last on beat 4; port 0 valid from beat 2 -> idx stays 2 for 4 beats; port 0 iresp stays 0 until granted after the IDLE cycle.
- Reset asserted on beat 2 of a 4-beat burst -> next cycle oreq.valid=0, state IDLE, rr_ptr=0; port 1 valid afterwards is granted 1 cycle later.
- RR wrap: NUM_PORTS=3, idx=2 completes -> rr_ptr=0; ports 0 and 1 valid -> port 0 wins.
- CBUS_ARB_PERF_EN: 5 completions on port 1, 2 on port 0 -> grant_cnt[1]=5, grant_cnt[0]=2; after reset both 0.

Source files
------------

// File: rtl/cbus_arbiter_rr_pkg.sv
// Common CBus package.
// Contents:
//   - cbus_req_t / cbus_resp_t : the cache-bus request and response beats.
//   - arb_state_t              : arbiter FSM states.
//   - CBUS_ARB_MAX_PORTS       : largest supported requester count.
//   - wrap_index()             : single-step modulo helper for ring indices.
package cbus_arbiter_rr_pkg;

  localparam int CBUS_ARB_MAX_PORTS = 8;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  len;    // beats minus one
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Reduce an index that is at most 2*n-1 back into the range [0, n).
  function automatic int unsigned wrap_index(input int unsigned i, input int unsigned n);
    if (i >= n) begin
      return i - n;
    end else begin
      return i;
    end
  endfunction

endpackage

// File: rtl/cbus_arbiter_rr_chk.sv
// cbus_arbiter_rr_chk: simulation-only protocol checker for the arbiter.
// Ports:
//   clk, reset    in  1  clock and synchronous active-high reset
//   busy          in  1  arbiter is holding a grant
//   granted_valid in  1  valid of the currently granted requester
module cbus_arbiter_rr_chk (
  input logic clk,
  input logic reset,
  input logic busy,
  input logic granted_valid
);

  // A granted requester must keep valid asserted until its burst ends.
  a_valid_held: assert property (@(posedge clk) disable iff (reset) busy |-> granted_valid);

endmodule

// File: rtl/cbus_arbiter_rr_pick.sv
// cbus_arb_pick: purely combinational requester picker, shared by bus muxes.
// Ports:
//   valid     in  NUM_PORTS  request valid vector
//   rr_ptr    in  IDX_W      highest-priority index in round-robin mode
//   rr_mode   in  1          1 = round-robin scan from rr_ptr, 0 = lowest index wins
//   winner    out IDX_W      selected index (0 when nothing is valid)
//   any_valid out 1          at least one request is valid
module cbus_arb_pick
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [IDX_W-1:0]     rr_ptr,
  input  logic                 rr_mode,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_valid
);

  int unsigned      cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             found_s;

  // Scan candidates in priority order; the first valid one wins.
  always_comb begin
    winner     = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    any_valid  = |valid;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (rr_mode) begin
        cand_s = wrap_index(32'(rr_ptr) + k, NUM_PORTS);
      end else begin
        cand_s = k;
      end
      cand_idx_s = IDX_W'(cand_s);
      if (!found_s && valid[cand_idx_s]) begin
        winner  = cand_idx_s;
        found_s = 1'b1;
      end else begin
        // an earlier candidate already won, or this one is idle
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// cbus_arbiter_rr: N-port cache-bus arbiter with fixed-priority or
// round-robin policy. A grant is held for a whole burst and released on the
// response beat carrying last; at least one idle cycle separates grants.
// Optional feature macro: CBUS_ARB_PERF_EN adds per-port completion counters.
// Ports:
//   clk        in   1                       clock
//   reset      in   1                       synchronous, active-high
//   ireqs      in   NUM_PORTS x cbus_req_t  per-port requests
//   iresps     out  NUM_PORTS x cbus_resp_t per-port responses
//   oreq       out  cbus_req_t              request to memory
//   oresp      in   cbus_resp_t             response from memory
//   grant_cnt  out  NUM_PORTS x 32          completed transactions per port
//                                           (only with CBUS_ARB_PERF_EN)
module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int RR_EN     = 1,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_PORTS],
  output cbus_resp_t iresps [NUM_PORTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
`ifdef CBUS_ARB_PERF_EN
  ,
  output logic [31:0] grant_cnt [NUM_PORTS]
`endif
);

  arb_state_t           state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic                 done_s;
  logic [NUM_PORTS-1:0] valid_vec_s;
  logic [IDX_W-1:0]     winner_s;
  logic                 any_valid_s;
  logic                 rr_mode_s;
  logic                 busy_s;
  logic                 gnt_valid_s;

  assign rr_mode_s = (RR_EN != 0) ? 1'b1 : 1'b0;

  // Collect the request valid bits for the picker.
  always_comb begin
    valid_vec_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_vec_s[i] = ireqs[i].valid;
    end
  end

  cbus_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .valid     (valid_vec_s),
    .rr_ptr    (rr_ptr_r),
    .rr_mode   (rr_mode_s),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // State, grant index and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ARB_IDLE;
      idx_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      rr_ptr_r <= rr_ptr_s;
    end
  end

  // Next-state logic and bus routing; outputs depend only on registered
  // state/idx plus the live request/response, so there is no buffering.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    rr_ptr_s = rr_ptr_r;
    done_s   = 1'b0;
    oreq     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
    end
    case (state_r)
      ARB_IDLE: begin
        if (any_valid_s) begin
          idx_s   = winner_s;
          state_s = ARB_BUSY;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        oreq          = ireqs[idx_r];
        iresps[idx_r] = oresp;
        if (oresp.ready && oresp.last) begin
          done_s  = 1'b1;
          state_s = ARB_IDLE;
          // The port just served drops to lowest priority.
          if (RR_EN != 0) begin
            rr_ptr_s = IDX_W'(wrap_index(32'(idx_r) + 32'd1, NUM_PORTS));
          end else begin
            rr_ptr_s = rr_ptr_r;
          end
        end else begin
          state_s = ARB_BUSY;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  assign busy_s      = (state_r == ARB_BUSY);
  assign gnt_valid_s = ireqs[idx_r].valid;

  cbus_arbiter_rr_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .busy          (busy_s),
    .granted_valid (gnt_valid_s)
  );

`ifdef CBUS_ARB_PERF_EN
  logic [31:0] cnt_r [NUM_PORTS];

  // Count completed transactions per port; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (done_s && (idx_r == IDX_W'(i))) begin
          cnt_r[i] <= cnt_r[i] + 32'd1;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Expose the counters.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_cnt[i] = cnt_r[i];
    end
  end
`endif

endmodule
